// File: rtl/ptw_req_arbiter_if.sv
// Handshake bundle between the ITLB/DTLB miss ports, the page-table walker
// and the arbiter that shares the walker between them.
interface ptw_req_arbiter_if #(
    parameter int VADDR_W = 39
);
    logic               flush_i;
    logic               itlb_req_valid_i;
    logic [VADDR_W-1:0] itlb_req_vaddr_i;
    logic               itlb_req_ready_o;
    logic               dtlb_req_valid_i;
    logic [VADDR_W-1:0] dtlb_req_vaddr_i;
    logic               dtlb_req_is_store_i;
    logic               dtlb_req_ready_o;
    logic               ptw_req_valid_o;
    logic [VADDR_W-1:0] ptw_req_vaddr_o;
    logic               ptw_req_is_store_o;
    logic               ptw_req_is_instr_o;
    logic               ptw_req_ready_i;
    logic               ptw_done_i;
    logic               ptw_error_i;
    logic               itlb_resp_valid_o;
    logic               dtlb_resp_valid_o;
    logic               resp_error_o;
    logic               busy_o;

    modport master (
        output flush_i,
        output itlb_req_valid_i, itlb_req_vaddr_i,
        input  itlb_req_ready_o,
        output dtlb_req_valid_i, dtlb_req_vaddr_i, dtlb_req_is_store_i,
        input  dtlb_req_ready_o,
        input  ptw_req_valid_o, ptw_req_vaddr_o, ptw_req_is_store_o, ptw_req_is_instr_o,
        output ptw_req_ready_i, ptw_done_i, ptw_error_i,
        input  itlb_resp_valid_o, dtlb_resp_valid_o, resp_error_o,
        input  busy_o
    );

    modport slave (
        input  flush_i,
        input  itlb_req_valid_i, itlb_req_vaddr_i,
        output itlb_req_ready_o,
        input  dtlb_req_valid_i, dtlb_req_vaddr_i, dtlb_req_is_store_i,
        output dtlb_req_ready_o,
        output ptw_req_valid_o, ptw_req_vaddr_o, ptw_req_is_store_o, ptw_req_is_instr_o,
        input  ptw_req_ready_i, ptw_done_i, ptw_error_i,
        output itlb_resp_valid_o, dtlb_resp_valid_o, resp_error_o,
        output busy_o
    );
endinterface

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between ITLB and DTLB misses: DTLB-first
// arbitration with a bounded ITLB starvation window and flush-safe draining.
module ptw_req_arbiter #(
    parameter int VADDR_W        = 39,
    parameter int MAX_STARVE     = 4,
    parameter bit PROTO_CHECK_EN = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    ptw_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    state_e             state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    logic [VADDR_W-1:0] vaddr_q, vaddr_d;
    logic               is_store_q, is_store_d;
    logic               is_instr_q, is_instr_d;
    logic               req_valid_q, req_valid_d;
    logic               itlb_resp_q, itlb_resp_d;
    logic               dtlb_resp_q, dtlb_resp_d;
    logic               resp_err_q, resp_err_d;
    logic               busy_q, busy_d;
    logic               grant_itlb;
    logic               grant_dtlb;

    // ITLB only overrides DTLB once it has been passed over MAX_STARVE times.
    always_comb begin
        grant_itlb = 1'b0;
        grant_dtlb = 1'b0;
        if (state_q == S_IDLE && !bus.flush_i) begin
            if (bus.itlb_req_valid_i &&
                (starve_q == STARVE_MAX || !bus.dtlb_req_valid_i)) begin
                grant_itlb = 1'b1;
            end else if (bus.dtlb_req_valid_i) begin
                grant_dtlb = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        vaddr_d     = vaddr_q;
        is_store_d  = is_store_q;
        is_instr_d  = is_instr_q;
        itlb_resp_d = 1'b0;
        dtlb_resp_d = 1'b0;
        resp_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_itlb) begin
                    vaddr_d    = bus.itlb_req_vaddr_i;
                    is_store_d = 1'b0;
                    is_instr_d = 1'b1;
                    starve_d   = 4'd0;
                    state_d    = S_ISSUE;
                end else if (grant_dtlb) begin
                    vaddr_d    = bus.dtlb_req_vaddr_i;
                    is_store_d = bus.dtlb_req_is_store_i;
                    is_instr_d = 1'b0;
                    if (bus.itlb_req_valid_i && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ptw_req_ready_i) begin
                    state_d = bus.flush_i ? S_DRAIN : S_WAIT;
                end else if (bus.flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.ptw_done_i) begin
                    if (!bus.flush_i) begin
                        itlb_resp_d = is_instr_q;
                        dtlb_resp_d = !is_instr_q;
                        resp_err_d  = bus.ptw_error_i;
                    end
                    state_d = S_IDLE;
                end else if (bus.flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The walk already left; its result is swallowed here.
                if (bus.ptw_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            vaddr_q     <= '0;
            is_store_q  <= 1'b0;
            is_instr_q  <= 1'b0;
            req_valid_q <= 1'b0;
            itlb_resp_q <= 1'b0;
            dtlb_resp_q <= 1'b0;
            resp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            vaddr_q     <= vaddr_d;
            is_store_q  <= is_store_d;
            is_instr_q  <= is_instr_d;
            req_valid_q <= req_valid_d;
            itlb_resp_q <= itlb_resp_d;
            dtlb_resp_q <= dtlb_resp_d;
            resp_err_q  <= resp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Grants are combinational, so mask them while reset holds the FSM.
    assign bus.itlb_req_ready_o   = grant_itlb & ~rst_i;
    assign bus.dtlb_req_ready_o   = grant_dtlb & ~rst_i;
    assign bus.ptw_req_valid_o    = req_valid_q;
    assign bus.ptw_req_vaddr_o    = vaddr_q;
    assign bus.ptw_req_is_store_o = is_store_q;
    assign bus.ptw_req_is_instr_o = is_instr_q;
    assign bus.itlb_resp_valid_o  = itlb_resp_q;
    assign bus.dtlb_resp_valid_o  = dtlb_resp_q;
    assign bus.resp_error_o       = resp_err_q;
    assign bus.busy_o             = busy_q;

    if (PROTO_CHECK_EN) begin : g_proto_chk
        a_done_only_when_walking : assert property (
            @(posedge clk_i) disable iff (rst_i)
            !(bus.ptw_done_i && (state_q == S_IDLE || state_q == S_ISSUE))
        );
    end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Directed bench for ptw_req_arbiter: single miss, contention/starvation,
// backpressure with fault, flushes in ISSUE and WAIT, and async reset.
module tb_ptw_req_arbiter;

    localparam int VADDR_W = 39;
    localparam int MAXS    = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ptw_req_arbiter_if #(.VADDR_W(VADDR_W)) bus ();

    ptw_req_arbiter #(
        .VADDR_W(VADDR_W),
        .MAX_STARVE(MAXS),
        .PROTO_CHECK_EN(1'b0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Both requesters held valid; ITLB must win every (MAXS+1)-th grant.
    task automatic contend(input int n);
        logic exp_i;
        logic prev_i;
        prev_i = 1'b0;
        bus.itlb_req_valid_i    = 1'b1;
        bus.itlb_req_vaddr_i    = 39'h11_0000_0000;
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h22_0000_0000;
        bus.dtlb_req_is_store_i = 1'b0;
        bus.ptw_req_ready_i     = 1'b1;
        for (int g = 0; g < n; g++) begin
            exp_i = ((g % (MAXS + 1)) == MAXS);
            smp();
            if (g > 0) begin
                chk("contend_iresp", 64'(bus.itlb_resp_valid_o), 64'(prev_i));
                chk("contend_dresp", 64'(bus.dtlb_resp_valid_o), 64'(!prev_i));
            end
            chk("contend_igrant", 64'(bus.itlb_req_ready_o), 64'(exp_i));
            chk("contend_dgrant", 64'(bus.dtlb_req_ready_o), 64'(!exp_i));
            cyc();
            if (g == n - 1) begin
                bus.itlb_req_valid_i = 1'b0;
                bus.dtlb_req_valid_i = 1'b0;
            end
            smp();
            chk("contend_instr", 64'(bus.ptw_req_is_instr_o), 64'(exp_i));
            cyc();
            bus.ptw_done_i = 1'b1;
            cyc();
            bus.ptw_done_i = 1'b0;
            prev_i = exp_i;
        end
        smp();
        chk("contend_last_iresp", 64'(bus.itlb_resp_valid_o), 64'(prev_i));
        chk("contend_last_dresp", 64'(bus.dtlb_resp_valid_o), 64'(!prev_i));
        cyc();
        bus.ptw_req_ready_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.flush_i             = 1'b0;
        bus.itlb_req_valid_i    = 1'b0;
        bus.itlb_req_vaddr_i    = '0;
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h33_3333_3000;
        bus.dtlb_req_is_store_i = 1'b1;
        bus.ptw_req_ready_i     = 1'b0;
        bus.ptw_done_i          = 1'b0;
        bus.ptw_error_i         = 1'b0;

        // Reset state
        cyc();
        smp();
        chk("rst_dready", 64'(bus.dtlb_req_ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_pvalid", 64'(bus.ptw_req_valid_o), 64'd0);
        chk("rst_vaddr", 64'(bus.ptw_req_vaddr_o), 64'd0);
        chk("rst_resp", 64'({bus.itlb_resp_valid_o, bus.dtlb_resp_valid_o, bus.resp_error_o}), 64'd0);
        cyc();
        rst = 1'b0;
        bus.dtlb_req_valid_i = 1'b0;
        cyc();

        // Single DTLB miss, minimum latency
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h40_0000_1000;
        bus.dtlb_req_is_store_i = 1'b1;
        bus.ptw_req_ready_i     = 1'b1;
        smp();
        chk("t1_dready", 64'(bus.dtlb_req_ready_o), 64'd1);
        chk("t1_iready", 64'(bus.itlb_req_ready_o), 64'd0);
        cyc();
        bus.dtlb_req_valid_i = 1'b0;
        smp();
        chk("t1_pvalid", 64'(bus.ptw_req_valid_o), 64'd1);
        chk("t1_vaddr", 64'(bus.ptw_req_vaddr_o), 64'h40_0000_1000);
        chk("t1_store", 64'(bus.ptw_req_is_store_o), 64'd1);
        chk("t1_instr", 64'(bus.ptw_req_is_instr_o), 64'd0);
        chk("t1_dready_issue", 64'(bus.dtlb_req_ready_o), 64'd0);
        cyc();
        bus.ptw_done_i = 1'b1;
        smp();
        chk("t1_pvalid_wait", 64'(bus.ptw_req_valid_o), 64'd0);
        chk("t1_busy_wait", 64'(bus.busy_o), 64'd1);
        cyc();
        bus.ptw_done_i = 1'b0;
        smp();
        chk("t1_dresp", 64'(bus.dtlb_resp_valid_o), 64'd1);
        chk("t1_iresp", 64'(bus.itlb_resp_valid_o), 64'd0);
        chk("t1_err", 64'(bus.resp_error_o), 64'd0);
        chk("t1_busy_idle", 64'(bus.busy_o), 64'd0);
        cyc();
        smp();
        chk("t1_dresp_low", 64'(bus.dtlb_resp_valid_o), 64'd0);
        cyc();

        // Contention and starvation bound (two full rounds)
        contend(2 * (MAXS + 1));

        // PTW backpressure then faulted walk, ITLB owner
        bus.itlb_req_valid_i = 1'b1;
        bus.itlb_req_vaddr_i = 39'h12_3456_7000;
        smp();
        chk("t3_iready", 64'(bus.itlb_req_ready_o), 64'd1);
        cyc();
        bus.itlb_req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.ptw_req_ready_i = 1'b1;
            smp();
            chk("t3_pvalid_hold", 64'(bus.ptw_req_valid_o), 64'd1);
            chk("t3_vaddr_hold", 64'(bus.ptw_req_vaddr_o), 64'h12_3456_7000);
            cyc();
        end
        bus.ptw_req_ready_i = 1'b0;
        smp();
        chk("t3_pvalid_drop", 64'(bus.ptw_req_valid_o), 64'd0);
        chk("t3_instr", 64'(bus.ptw_req_is_instr_o), 64'd1);
        cyc();
        bus.ptw_done_i  = 1'b1;
        bus.ptw_error_i = 1'b1;
        smp();
        chk("t3_no_early_resp", 64'(bus.itlb_resp_valid_o), 64'd0);
        cyc();
        bus.ptw_done_i  = 1'b0;
        bus.ptw_error_i = 1'b0;
        smp();
        chk("t3_iresp", 64'(bus.itlb_resp_valid_o), 64'd1);
        chk("t3_dresp", 64'(bus.dtlb_resp_valid_o), 64'd0);
        chk("t3_err", 64'(bus.resp_error_o), 64'd1);
        cyc();
        smp();
        chk("t3_err_low", 64'({bus.itlb_resp_valid_o, bus.resp_error_o}), 64'd0);
        cyc();

        // Flush in IDLE blocks grant; flush in ISSUE aborts; stray done ignored
        bus.flush_i             = 1'b1;
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h00_dead_b000;
        bus.dtlb_req_is_store_i = 1'b0;
        smp();
        chk("t4_flush_idle_ready", 64'(bus.dtlb_req_ready_o), 64'd0);
        cyc();
        bus.flush_i = 1'b0;
        smp();
        chk("t4_dready", 64'(bus.dtlb_req_ready_o), 64'd1);
        cyc();
        bus.dtlb_req_valid_i = 1'b0;
        bus.flush_i          = 1'b1;
        smp();
        chk("t4_pvalid_issue", 64'(bus.ptw_req_valid_o), 64'd1);
        cyc();
        bus.flush_i    = 1'b0;
        bus.ptw_done_i = 1'b1;
        smp();
        chk("t4_busy_idle", 64'(bus.busy_o), 64'd0);
        chk("t4_pvalid_gone", 64'(bus.ptw_req_valid_o), 64'd0);
        cyc();
        bus.ptw_done_i = 1'b0;
        smp();
        chk("t4_no_resp", 64'({bus.itlb_resp_valid_o, bus.dtlb_resp_valid_o}), 64'd0);
        chk("t4_still_idle", 64'(bus.busy_o), 64'd0);
        cyc();

        // Flush in WAIT, done three cycles later, pending ITLB then granted
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h01_2345_6000;
        bus.dtlb_req_is_store_i = 1'b1;
        bus.ptw_req_ready_i     = 1'b1;
        smp();
        chk("t5_dready", 64'(bus.dtlb_req_ready_o), 64'd1);
        cyc();
        bus.dtlb_req_valid_i = 1'b0;
        cyc();
        bus.flush_i          = 1'b1;
        bus.itlb_req_valid_i = 1'b1;
        bus.itlb_req_vaddr_i = 39'h0a_bcde_f000;
        smp();
        chk("t5_iready_wait", 64'(bus.itlb_req_ready_o), 64'd0);
        cyc();
        bus.flush_i = 1'b0;
        smp();
        chk("t5_busy_drain", 64'(bus.busy_o), 64'd1);
        chk("t5_iready_drain", 64'(bus.itlb_req_ready_o), 64'd0);
        cyc();
        cyc();
        bus.ptw_done_i = 1'b1;
        smp();
        chk("t5_iready_done", 64'(bus.itlb_req_ready_o), 64'd0);
        cyc();
        bus.ptw_done_i = 1'b0;
        smp();
        chk("t5_igrant_reentry", 64'(bus.itlb_req_ready_o), 64'd1);
        chk("t5_no_resp", 64'({bus.itlb_resp_valid_o, bus.dtlb_resp_valid_o}), 64'd0);
        cyc();
        bus.itlb_req_valid_i = 1'b0;
        smp();
        chk("t5_vaddr", 64'(bus.ptw_req_vaddr_o), 64'h0a_bcde_f000);
        chk("t5_instr_store", 64'({bus.ptw_req_is_instr_o, bus.ptw_req_is_store_o}), 64'b10);
        cyc();
        bus.ptw_done_i = 1'b1;
        cyc();
        bus.ptw_done_i = 1'b0;
        smp();
        chk("t5_iresp", 64'(bus.itlb_resp_valid_o), 64'd1);
        chk("t5_dresp", 64'(bus.dtlb_resp_valid_o), 64'd0);
        cyc();

        // Async reset mid-WAIT with starve_cnt nonzero
        bus.itlb_req_valid_i    = 1'b1;
        bus.itlb_req_vaddr_i    = 39'h05_0000_0000;
        bus.dtlb_req_valid_i    = 1'b1;
        bus.dtlb_req_vaddr_i    = 39'h7f_ffff_f000;
        bus.dtlb_req_is_store_i = 1'b1;
        bus.ptw_req_ready_i     = 1'b1;
        smp();
        chk("t6_dready", 64'(bus.dtlb_req_ready_o), 64'd1);
        cyc();
        bus.itlb_req_valid_i = 1'b0;
        bus.dtlb_req_valid_i = 1'b0;
        cyc();
        bus.dtlb_req_valid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("t6_rst_pfields", 64'({bus.ptw_req_valid_o, bus.ptw_req_is_store_o, bus.ptw_req_is_instr_o}), 64'd0);
        chk("t6_rst_vaddr", 64'(bus.ptw_req_vaddr_o), 64'd0);
        chk("t6_rst_dready", 64'(bus.dtlb_req_ready_o), 64'd0);
        chk("t6_rst_resp", 64'({bus.itlb_resp_valid_o, bus.dtlb_resp_valid_o, bus.resp_error_o}), 64'd0);
        bus.dtlb_req_valid_i = 1'b0;
        bus.ptw_req_ready_i  = 1'b0;
        #3;
        rst = 1'b0;
        cyc();

        // starve_cnt back at 0: ITLB must wait a full window again
        contend(MAXS + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
